// File: rtl/audio_out_streamer_if.sv
// Datapath-to-streamer bus: sample write strobe, end-of-stream, status flags and
// the three-wire serial link toward the DAC.
interface audio_out_streamer_if #(parameter int DATA_W = 11);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              finish_in;
  logic              stall;
  logic              overflow;
  logic              sclk;
  logic              fs;
  logic              sdata;
  logic              done;

  modport master (output sample_in, sample_valid, finish_in,
                  input  stall, overflow, sclk, fs, sdata, done);
  modport slave  (input  sample_in, sample_valid, finish_in,
                  output stall, overflow, sclk, fs, sdata, done);
endinterface

// File: rtl/audio_out_streamer.sv
// Buffers processed audio samples in a small FIFO and shifts them out MSB-first
// on a bit-clock / frame-sync / data link, with back-pressure and end-of-stream.
module audio_out_streamer #(
  parameter int DATA_W  = 11,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4
)(
  input  logic                 clkFPGA,
  input  logic                 rst,
  audio_out_streamer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MSB = BW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_finish_pend, r_done, r_overflow;
  logic [DW-1:0]     r_div, w_div_nxt;
  logic [BW-1:0]     r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_fs, w_fs_nxt;
  logic              w_push, w_pop, w_full, w_nonempty;

  assign w_full     = (r_count == FULL);
  assign w_nonempty = (r_count != '0);
  // A full FIFO rejects the strobe even if the serializer pops this cycle.
  assign w_push     = bus.sample_valid && !w_full;

  assign bus.stall    = w_full;
  assign bus.overflow = r_overflow;
  assign bus.done     = r_done;
  assign bus.sclk     = r_sclk;
  assign bus.fs       = r_fs;
  assign bus.sdata    = r_shreg[DATA_W-1];

  always_ff @(posedge clkFPGA) begin
    if (w_push) r_mem[r_wptr] <= bus.sample_in;
  end

  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_sclk  <= w_sclk_nxt;
      r_fs    <= w_fs_nxt;
    end
  end

  // sdata is the shift register MSB, so it only moves when sclk falls.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_sclk_nxt  = r_sclk;
    w_fs_nxt    = r_fs;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rptr];
          w_fs_nxt    = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_bit_nxt   = BIT_MSB;
          w_div_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_div != DIV_MAX) begin
          w_div_nxt = r_div + DW'(1);
        end else begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit != '0) begin
              w_bit_nxt   = r_bit - BW'(1);
              w_shreg_nxt = r_shreg << 1;
              w_fs_nxt    = 1'b0;
            end else if (w_nonempty) begin
              w_pop       = 1'b1;
              w_shreg_nxt = r_mem[r_rptr];
              w_fs_nxt    = 1'b1;
              w_bit_nxt   = BIT_MSB;
            end else begin
              w_shreg_nxt = '0;
              w_fs_nxt    = 1'b0;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      r_finish_pend <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_finish_pend <= r_finish_pend | bus.finish_in;
      r_done        <= r_done | ((r_state == IDLE) && !w_nonempty && r_finish_pend);
      r_overflow    <= r_overflow | (bus.sample_valid && w_full);
    end
  end
endmodule

// File: tb/tb_audio_out_streamer.sv
// Directed bench for audio_out_streamer: per-cycle compare against a timeline
// model of the serial link, plus hand-computed word/timing expectations.
module tb_audio_out_streamer;
  localparam int DATA_W  = 11;
  localparam int DEPTH   = 16;
  localparam int CLK_DIV = 4;
  localparam int BIT_P   = 2 * CLK_DIV;
  localparam int WORD    = BIT_P * DATA_W;

  logic clkFPGA = 1'b0;
  logic rst     = 1'b0;
  always #5 clkFPGA = ~clkFPGA;

  audio_out_streamer_if #(.DATA_W(DATA_W)) bus();

  audio_out_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clkFPGA (clkFPGA),
    .rst     (rst),
    .bus     (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.sclk, bus.fs, bus.sdata, bus.stall, bus.overflow, bus.done};
  endfunction

  always @(negedge clkFPGA) cyc <= cyc + 1;

  // Timeline model: a word occupies WORD cycles; offset t gives sclk/fs/bit.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_cur = '0;
  bit m_busy = 0, m_fin = 0, m_done = 0, m_ovf = 0;
  int m_t = 0;

  always @(posedge clkFPGA or posedge rst) begin : model
    bit full;
    logic [5:0] exp;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_t = 0; m_fin = 0; m_done = 0; m_ovf = 0; m_cur = '0;
    end else begin
      full = (m_q.size() == DEPTH);
      if (!m_busy && m_q.size() == 0 && m_fin) m_done = 1;
      if (bus.finish_in) m_fin = 1;
      if (bus.sample_valid && full) m_ovf = 1;
      if (!m_busy) begin
        if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_busy = 1; m_t = 0; end
      end else begin
        m_t++;
        if (m_t == WORD) begin
          if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_t = 0; end
          else m_busy = 0;
        end
      end
      if (bus.sample_valid && !full) m_q.push_back(bus.sample_in);
      exp[5] = m_busy && ((m_t % BIT_P) >= CLK_DIV);
      exp[4] = m_busy && (m_t < BIT_P);
      exp[3] = m_busy && m_cur[DATA_W-1 - m_t / BIT_P];
      exp[2] = (m_q.size() == DEPTH);
      exp[1] = m_ovf;
      exp[0] = m_done;
      #1;
      if (!rst) chk("cycle outputs", outs(), exp);
    end
  end

  // Link receiver: shifts sdata on each sclk rise, fs marks the MSB.
  logic [DATA_W-1:0] rx_q[$];
  logic [DATA_W-1:0] rx_sh = '0;
  int rx_n = 0, n_rise = 0, fs_hi = 0, done_cyc = -1;
  int fs_cyc[$];

  always @(posedge bus.sclk) begin
    n_rise++;
    rx_sh = bus.fs ? DATA_W'(bus.sdata) : {rx_sh[DATA_W-2:0], bus.sdata};
    rx_n  = bus.fs ? 1 : rx_n + 1;
    if (rx_n == DATA_W) rx_q.push_back(rx_sh);
  end
  always @(posedge bus.fs)   fs_cyc.push_back(cyc);
  always @(posedge bus.done) done_cyc = cyc;
  always @(negedge clkFPGA)  if (bus.fs === 1'b1) fs_hi++;

  task automatic clear_obs();
    rx_q.delete(); fs_cyc.delete(); n_rise = 0; fs_hi = 0;
  endtask

  task automatic strobe_seq(input logic [DATA_W-1:0] v[$]);
    foreach (v[k]) begin
      @(negedge clkFPGA);
      bus.sample_in = v[k]; bus.sample_valid = 1'b1;
    end
    @(negedge clkFPGA);
    bus.sample_valid = 1'b0;
  endtask

  function automatic int rx_at(input int k);
    return (k < rx_q.size()) ? int'(rx_q[k]) : -1;
  endfunction
  function automatic int fs_at(input int k);
    return (k < fs_cyc.size()) ? fs_cyc[k] : -100000;
  endfunction

  initial begin : stim
    logic [DATA_W-1:0] v[$];
    logic [DATA_W-1:0] sent[$];
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.finish_in = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset outputs", outs(), 6'b0);
    repeat (3) @(negedge clkFPGA);
    rst = 1'b0;
    repeat (5) @(negedge clkFPGA);
    chk("idle after reset", outs(), 6'b0);

    // single word 0x5A3 -> 1,0,1,1,0,1,0,0,0,1,1
    clear_obs();
    v = '{11'h5A3};
    strobe_seq(v);
    repeat (WORD + 10) @(negedge clkFPGA);
    chk("single rx count", rx_q.size(), 1);
    chk("single rx word", rx_at(0), 32'h5A3);
    chk("single sclk rises", n_rise, 11);
    chk("single fs cycles", fs_hi, 8);
    chk("single idle", outs(), 6'b0);

    // back-to-back words with no gap
    clear_obs();
    v = '{11'h001, 11'h7FF, 11'h400};
    strobe_seq(v);
    repeat (3 * WORD + 10) @(negedge clkFPGA);
    chk("b2b rx count", rx_q.size(), 3);
    chk("b2b word0", rx_at(0), 32'h001);
    chk("b2b word1", rx_at(1), 32'h7FF);
    chk("b2b word2", rx_at(2), 32'h400);
    chk("b2b fs offset1", fs_at(1) - fs_at(0), 88);
    chk("b2b fs offset2", fs_at(2) - fs_at(0), 176);
    chk("b2b fs cycles", fs_hi, 24);

    // overflow: 20 consecutive strobes from empty
    clear_obs();
    sent.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clkFPGA);
      if (i >= 15) chk("stall before strobe", bus.stall, (i >= 17) ? 1 : 0);
      bus.sample_in = DATA_W'(i * 73 + 5); bus.sample_valid = 1'b1;
      sent.push_back(DATA_W'(i * 73 + 5));
    end
    @(negedge clkFPGA);
    bus.sample_valid = 1'b0;
    chk("overflow flag", bus.overflow, 1);
    repeat (17 * WORD + 10) @(negedge clkFPGA);
    chk("overflow rx count", rx_q.size(), 17);
    for (int k = 0; k < 17; k++) chk("overflow rx order", rx_at(k), int'(sent[k]));
    chk("overflow stall released", bus.stall, 0);

    // finish with two words pending
    clear_obs();
    v = '{11'h123, 11'h456};
    strobe_seq(v);
    bus.finish_in = 1'b1;
    @(negedge clkFPGA);
    bus.finish_in = 1'b0;
    repeat (WORD + 50) @(negedge clkFPGA);
    chk("done held low", bus.done, 0);
    repeat (WORD) @(negedge clkFPGA);
    chk("done set", bus.done, 1);
    chk("done latency", done_cyc - fs_at(0), 177);
    chk("finish rx word1", rx_at(1), 32'h456);

    // samples after done still go out, done stays set
    clear_obs();
    v = '{11'h2C5};
    strobe_seq(v);
    repeat (WORD + 10) @(negedge clkFPGA);
    chk("post-done rx word", rx_at(0), 32'h2C5);
    chk("post-done done", bus.done, 1);

    // reset during bit 5 of a word with 3 queued
    clear_obs();
    v = '{11'h3F0, 11'h0AA, 11'h555, 11'h1E1};
    strobe_seq(v);
    repeat (43) @(negedge clkFPGA);
    chk("pre-reset sclk", bus.sclk, 1);
    #2 rst = 1'b1;
    #1 chk("async reset outputs", outs(), 6'b0);
    repeat (2) @(negedge clkFPGA);
    rst = 1'b0;
    clear_obs();
    repeat (4 * WORD) @(negedge clkFPGA);
    chk("no stale words", rx_q.size(), 0);
    chk("no stale frames", fs_cyc.size(), 0);
    chk("quiet after reset", outs(), 6'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
